capture_controller: RTL and testbench

- Downstream consumer of the trigger's `run` output. Owns the capture sequence into a sample RAM.
- Sequence: pre-fills a ring buffer, arms the trigger, detects `run`, records the trigger address, writes a programmed number of post-trigger samples, then reports done with the capture window location.
- Sits between the host/config registers, the trigger block and the sample RAM write port.

---
 rtl/capture_controller.sv | 178 +++++++++++++++++
 tb/tb_capture_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// Capture sequencer: pre-fills a ring buffer in sample RAM, arms the trigger,
// records where the trigger fired, writes the post-trigger samples and then
// reports the location of the finished capture window.
module capture_controller #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic [ADDR_WIDTH:0]     pre_count,
    input  logic [ADDR_WIDTH:0]     post_count,
    input  logic                    run,
    output logic                    arm,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [SAMPLE_WIDTH-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   trig_addr,
    output logic [ADDR_WIDTH-1:0]   start_addr,
    output logic                    config_err
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARM,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    // Buffer depth expressed in the width of the pre+post sum.
    localparam logic [ADDR_WIDTH+1:0] DEPTH_W  = {2'b01, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH:0]     post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH:0]     pre_len_q, pre_len_d;
    logic [ADDR_WIDTH:0]     post_len_q, post_len_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [SAMPLE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                    config_err_q, config_err_d;
    logic                    wr_en;
    logic [ADDR_WIDTH+1:0]   window_len;

    // Requested window length; a window larger than the ring cannot be held.
    assign window_len = {1'b0, pre_count} + {1'b0, post_count};

    // Sequencer next-state logic plus the sample write path into the RAM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        config_err_d = 1'b0;
        wr_en        = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (window_len > DEPTH_W) begin
                            config_err_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            pre_len_d  = pre_count;
                            post_len_d = post_count;
                            pre_cnt_d  = CNT_ZERO;
                            state_d    = PRE;
                        end
                    end
                end
                PRE: begin
                    wr_en     = valid;
                    pre_cnt_d = pre_cnt_q + {{ADDR_WIDTH{1'b0}}, valid};
                    if (pre_cnt_d >= pre_len_q) begin
                        state_d = ARM;
                    end
                end
                ARM: begin
                    wr_en   = valid;
                    state_d = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    wr_en = valid;
                    if (run) begin
                        // The trigger judged the sample most recently written.
                        trig_addr_d = wr_ptr_q - ADDR_ONE;
                        post_cnt_d  = {{ADDR_WIDTH{1'b0}}, valid};
                        state_d     = POST;
                    end
                end
                POST: begin
                    // A sample on the run clock may already satisfy the post length.
                    wr_en      = valid && (post_cnt_q < post_len_q);
                    post_cnt_d = post_cnt_q + {{ADDR_WIDTH{1'b0}}, wr_en};
                    if (post_cnt_d >= post_len_q) begin
                        start_addr_d = trig_addr_q + ADDR_ONE - pre_len_q[ADDR_WIDTH-1:0];
                        state_d      = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (wr_en) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = dataIn;
            wr_ptr_d    = wr_ptr_q + ADDR_ONE;
        end
    end

    // State, counters and registered RAM write port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            config_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            config_err_q <= config_err_d;
        end
    end

    assign arm        = (state_q == ARM);
    assign busy       = (state_q == PRE) || (state_q == ARM) ||
                        (state_q == WAIT_TRIG) || (state_q == POST);
    assign done       = (state_q == DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    assign config_err = config_err_q;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller. Each capture is described as a
// timeline of clock intervals (interval t = the clock period ending at edge t,
// start sampled at edge 0); the expected phase boundaries and RAM writes are
// derived from sample counts, and every interval's outputs are compared.
module tb_capture_controller;

    localparam int SW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int H     = 256;
    localparam int NEVER = H + 100;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] dataIn = '0;
    logic [AW:0]   pre_count = '0;
    logic [AW:0]   post_count = '0;
    logic          run = 1'b0;
    logic          arm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;
    logic          config_err;

    capture_controller #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .valid(valid), .dataIn(dataIn), .pre_count(pre_count),
        .post_count(post_count), .run(run), .arm(arm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .trig_addr(trig_addr), .start_addr(start_addr), .config_err(config_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state carried between captures.
    int mdlPtr = 0;
    int mdlTrig = 0;
    int mdlStartAddr = 0;

    // Per-interval stimulus and expectations for the current capture.
    bit          v[H];
    logic [SW-1:0] d[H];
    bit          eArm[H], eBusy[H], eDone[H], eWe[H];
    int          eAddr[H];
    logic [SW-1:0] eData[H];
    int          tA, tR, tD, tAb, endT, ptrWork;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A sample offered in interval t lands in RAM (visible in t+1) unless aborted.
    task automatic writeAt(input int t);
        if (v[t] && t < tAb) begin
            eWe[t+1]   = 1'b1;
            eAddr[t+1] = ptrWork;
            eData[t+1] = d[t];
            ptrWork    = (ptrWork + 1) % DEPTH;
        end
    endtask

    task automatic computeModel(input int pre, input int post, input int gap);
        int cnt;
        int pc;
        int ptrAtRun;
        int t;
        for (int i = 0; i < H; i++) begin
            eArm[i] = 0; eBusy[i] = 0; eDone[i] = 0; eWe[i] = 0; eAddr[i] = 0; eData[i] = '0;
        end
        ptrWork = mdlPtr;
        ptrAtRun = 0;
        // Retain pre samples: the interval holding the pre-th sample ends the phase.
        cnt = 0;
        for (t = 1; t < H - 60; t++) begin
            eBusy[t] = 1;
            writeAt(t);
            cnt += int'(v[t]);
            if (cnt >= pre) break;
        end
        tA = t;
        eBusy[tA+1] = 1;
        eArm[tA+1]  = 1;
        writeAt(tA + 1);
        tR = tA + 1 + gap;
        for (t = tA + 2; t <= tR; t++) begin
            eBusy[t] = 1;
            if (t == tR) ptrAtRun = ptrWork;
            writeAt(t);
        end
        // The sample on the run interval is the first post sample.
        pc = int'(v[tR]);
        for (t = tR + 1; t < H - 10; t++) begin
            eBusy[t] = 1;
            if (pc >= post) break;
            writeAt(t);
            pc += int'(v[t]);
            if (pc >= post) break;
        end
        tD = t;
        endT = (tAb < tD + 2) ? tAb + 2 : tD + 2;
        for (t = tD + 1; t <= endT + 1; t++) eDone[t] = 1;
        for (t = tAb + 1; t < H; t++) begin
            eBusy[t] = 0; eArm[t] = 0; eDone[t] = 0;
        end
        if (tR < tAb) mdlTrig = (ptrAtRun - 1 + DEPTH) % DEPTH;
        if (tD < tAb) mdlStartAddr = (((mdlTrig + 1 - pre) % DEPTH) + DEPTH) % DEPTH;
        mdlPtr = ptrWork;
    endtask

    // vmode: 0 valid every clock, 1 every other clock, 2 random, 3 never.
    task automatic applyStimulus(input int pre, input int post, input int vmode,
                                 input int gap, input int abortAt);
        v[0] = 0;
        d[0] = SW'($urandom);
        for (int t = 1; t < H; t++) begin
            case (vmode)
                0: v[t] = 1;
                1: v[t] = (t % 2) == 1;
                2: v[t] = ($urandom % 4) != 0;
                default: v[t] = 0;
            endcase
            d[t] = SW'($urandom);
        end
        tAb = (abortAt < 0) ? NEVER : abortAt;
        computeModel(pre, post, gap);
        pre_count  = (AW+1)'(pre);
        post_count = (AW+1)'(post);
        for (int t = 0; t <= endT; t++) begin
            start  = (t == 0) || (t >= 1 && t <= tD && t <= tAb && ($urandom % 5) == 0);
            abort  = (t == tAb);
            valid  = v[t];
            dataIn = d[t];
            run    = (t == tR) || ((t <= tA + 1 || t > tR) && ($urandom % 3) == 0);
            @(posedge clock);
            @(negedge clock);
            checkOutput($sformatf("busy t=%0d", t + 1), 32'(busy), 32'(eBusy[t+1]));
            checkOutput($sformatf("arm t=%0d", t + 1), 32'(arm), 32'(eArm[t+1]));
            checkOutput($sformatf("done t=%0d", t + 1), 32'(done), 32'(eDone[t+1]));
            checkOutput($sformatf("mem_we t=%0d", t + 1), 32'(mem_we), 32'(eWe[t+1]));
            checkOutput($sformatf("config_err t=%0d", t + 1), 32'(config_err), 32'd0);
            if (eWe[t+1]) begin
                checkOutput($sformatf("mem_addr t=%0d", t + 1), 32'(mem_addr), 32'(eAddr[t+1]));
                checkOutput($sformatf("mem_wdata t=%0d", t + 1), 32'(mem_wdata), 32'(eData[t+1]));
            end
        end
        start = 0; abort = 0; valid = 0; run = 0;
        if (tR < tAb) checkOutput("trig_addr", 32'(trig_addr), 32'(mdlTrig));
        if (tD < tAb) checkOutput("start_addr", 32'(start_addr), 32'(mdlStartAddr));
    endtask

    task automatic applyBadConfig(input int pre, input int post);
        pre_count  = (AW+1)'(pre);
        post_count = (AW+1)'(post);
        start = 1;
        @(posedge clock);
        @(negedge clock);
        start = 0;
        checkOutput("cfg config_err pulse", 32'(config_err), 32'd1);
        checkOutput("cfg busy", 32'(busy), 32'd0);
        checkOutput("cfg done cleared", 32'(done), 32'd0);
        checkOutput("cfg arm", 32'(arm), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput("cfg config_err low", 32'(config_err), 32'd0);
            checkOutput("cfg idle busy", 32'(busy), 32'd0);
            checkOutput("cfg idle arm", 32'(arm), 32'd0);
            checkOutput("cfg idle mem_we", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " arm"}, 32'(arm), 32'd0);
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " trig_addr"}, 32'(trig_addr), 32'd0);
        checkOutput({tag, " start_addr"}, 32'(start_addr), 32'd0);
        checkOutput({tag, " config_err"}, 32'(config_err), 32'd0);
    endtask

    initial begin
        int n;
        $display("[TB] capture_controller bench starting");
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkAllZero("reset");
        reset_n = 1;
        @(negedge clock);

        // Nine writes before run, three post writes, window starts at 5.
        applyStimulus(4, 3, 0, 5, -1);
        checkOutput("plan1 trig_addr", 32'(trig_addr), 32'd8);
        checkOutput("plan1 start_addr", 32'(start_addr), 32'd5);

        applyStimulus(2, 2, 1, 2, -1);

        // Abort a long pre-fill to park the pointer at DEPTH-2, then capture across the wrap.
        n = (DEPTH - 2 - mdlPtr + DEPTH) % DEPTH;
        if (n != 0) applyStimulus(DEPTH, 0, 0, 1, n + 1);
        applyStimulus(3, 2, 0, 1, -1);

        applyStimulus(0, 0, 3, 2, -1);

        applyBadConfig(DEPTH, 1);

        // Abort in the middle of the post phase.
        applyStimulus(2, 6, 0, 2, 8);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(int'($urandom % 9), int'($urandom % 8), int'($urandom % 3),
                          1 + int'($urandom % 6),
                          (($urandom % 4) == 0) ? 1 + int'($urandom % 20) : -1);
        end

        // Asynchronous reset in the middle of a capture.
        pre_count = 5'd3; post_count = 5'd2; valid = 1; dataIn = 8'hA5; start = 1;
        @(posedge clock);
        @(negedge clock);
        start = 0;
        repeat (3) @(posedge clock);
        #2 reset_n = 0;
        #1 checkAllZero("async reset");
        valid = 0;
        @(negedge clock);
        reset_n = 1;
        mdlPtr = 0;
        mdlTrig = 0;
        @(negedge clock);
        applyStimulus(1, 1, 0, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
